prog_rom: RTL and testbench

Parametrised, synthesizable instruction memory for `Naive_CPU` simulation and FPGA bring-up. It replaces a constant driven onto `rom_data_i` with a loadable program store. A loader-side valid/ready port writes the program. A run/stop state machine gates the CPU, and the fetch port answers `rom_ce_o`/`rom_addr_o` with configurable read latency. A fetch counter supports the observer.

---
 rtl/prog_rom_pkg.sv | 22 ++
 rtl/prog_rom_rd_pipe.sv | 48 ++++
 rtl/prog_rom.sv | 149 ++++++++++++++
 tb/tb_prog_rom.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_rom_pkg.sv
// Shared types and helpers for the loadable program ROM used during Naive_CPU bring-up.
package prog_rom_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } prog_rom_state_t;

  localparam int FETCH_CNT_W = 32;

  function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] value);
    logic [FETCH_CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(FETCH_CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/prog_rom_rd_pipe.sv
// Fixed-latency valid/data shift register for fetch results.
// Idle stages carry FILL, so the output stage drives FILL whenever it holds no result.
module rd_pipe #(
  parameter int                 LATENCY = 1,
  parameter int                 INST_W  = 16,
  parameter logic [INST_W-1:0]  FILL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_data,
  output logic              out_valid,
  output logic [INST_W-1:0] out_data,
  output logic              empty
);

  logic [LATENCY-1:0] valid_r;
  logic [INST_W-1:0]  data_r [LATENCY];

  // Advance the pipeline one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_r[i] <= FILL;
      end
    end else begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_valid ? in_data : FILL;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  // Empty once nothing sits behind the output stage: the output drains on the next edge.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      empty = empty & ~valid_r[i];
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/prog_rom.sv
// Loadable instruction store for Naive_CPU: loader port writes the program,
// a LOAD/RUN/DRAIN machine gates the CPU, and fetches return after LATENCY cycles.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int                 INST_W  = 16,
  parameter int                 ADDR_W  = 16,
  parameter int                 DEPTH   = 64,
  parameter int                 LATENCY = 1,
  parameter logic [INST_W-1:0]  FILL    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [INST_W-1:0]      load_data,
  input  logic                   load_last,
  input  logic                   stop,
  output logic                   run,
  input  logic                   rom_ce,
  input  logic [ADDR_W-1:0]      rom_addr,
  output logic [INST_W-1:0]      rom_data,
  output logic                   rom_valid,
  output logic [FETCH_CNT_W-1:0] fetch_cnt,
  output logic                   load_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  prog_rom_state_t        state_r;
  prog_rom_state_t        state_nxt_s;
  logic [INST_W-1:0]      mem_r [DEPTH];
  logic                   load_fire_s;
  logic                   load_in_range_s;
  logic                   fetch_fire_s;
  logic                   enter_run_s;
  logic [INST_W-1:0]      rd_data_s;
  logic                   pipe_empty_s;
  logic [FETCH_CNT_W-1:0] fetch_cnt_r;
  logic                   load_err_r;

  assign load_fire_s     = (state_r == LOAD) && load_valid;
  assign load_in_range_s = (load_addr < DEPTH_A);
  assign fetch_fire_s    = (state_r == RUN) && rom_ce;
  assign enter_run_s     = (state_r == LOAD) && (state_nxt_s == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a dropped last beat still starts the run.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD: begin
        if (load_valid && load_last) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = LOAD;
      end
    endcase
  end

  // Program store is deliberately never reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (load_fire_s && load_in_range_s) begin
      mem_r[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  // Address lookup feeding the first pipeline stage.
  always_comb begin
    rd_data_s = FILL;
    if (rom_addr < DEPTH_A) begin
      rd_data_s = mem_r[rom_addr[IDX_W-1:0]];
    end else begin
      rd_data_s = FILL;
    end
  end

  rd_pipe #(
    .LATENCY (LATENCY),
    .INST_W  (INST_W),
    .FILL    (FILL)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fetch_fire_s),
    .in_data   (rd_data_s),
    .out_valid (rom_valid),
    .out_data  (rom_data),
    .empty     (pipe_empty_s)
  );

  // Fetch counter: restarts on each new run and saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_r <= '0;
    end else if (enter_run_s) begin
      fetch_cnt_r <= '0;
    end else if (fetch_fire_s) begin
      fetch_cnt_r <= sat_inc(fetch_cnt_r);
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  // Sticky flag for loader writes that fell outside the store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err_r <= 1'b0;
    end else if (load_fire_s && !load_in_range_s) begin
      load_err_r <= 1'b1;
    end else begin
      load_err_r <= load_err_r;
    end
  end

  assign run        = (state_r == RUN);
  assign load_ready = (state_r == LOAD);
  assign fetch_cnt  = fetch_cnt_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom: one instance with LATENCY=1/FILL=0 and one with
// LATENCY=3/FILL=F00D share the same stimulus; each is checked against hand-computed values.
module tb_prog_rom;

  localparam logic [15:0] FILL3 = 16'hF00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_last;
  logic        stop;
  logic        rom_ce;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic [15:0] rom_addr;

  logic        load_ready1, run1, rom_valid1, load_err1;
  logic [15:0] rom_data1;
  logic [31:0] fetch_cnt1;
  logic        load_ready3, run3, rom_valid3, load_err3;
  logic [15:0] rom_data3;
  logic [31:0] fetch_cnt3;

  int checks_cnt = 0;
  int err_cnt    = 0;

  logic [15:0] prog_w [4] = '{16'h3443, 16'h3481, 16'h0000, 16'h1234};
  logic [15:0] ord_a  [4] = '{16'd2, 16'd0, 16'd1, 16'd3};
  logic [15:0] ord_e  [4] = '{16'hBEEF, 16'h3443, 16'h3481, 16'h1234};

  always #5 clk = ~clk;

  prog_rom #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready1), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last), .stop(stop), .run(run1),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data1), .rom_valid(rom_valid1),
    .fetch_cnt(fetch_cnt1), .load_err(load_err1)
  );

  prog_rom #(.LATENCY(3), .FILL(FILL3)) u_dut3 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready3), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last), .stop(stop), .run(run3),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data3), .rom_valid(rom_valid3),
    .fetch_cnt(fetch_cnt3), .load_err(load_err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_addr = 16'h0;
    load_data = 16'h0; stop = 1'b0; rom_ce = 1'b0; rom_addr = 16'h0;
    tick(); tick();
    check_eq("rst_ready1", load_ready1, 32'd1);
    check_eq("rst_ready3", load_ready3, 32'd1);
    check_eq("rst_run1", run1, 32'd0);
    check_eq("rst_valid3", rom_valid3, 32'd0);
    check_eq("rst_data1", rom_data1, 32'h0);
    check_eq("rst_data3", rom_data3, 32'hF00D);
    check_eq("rst_cnt1", fetch_cnt1, 32'd0);
    check_eq("rst_err3", load_err3, 32'd0);
    rst = 1'b1;
    tick();

    // Load the 4-word program; a fetch during the last beat must not be accepted.
    for (int k = 0; k < 4; k++) begin
      load_valid = 1'b1; load_addr = 16'(k); load_data = prog_w[k]; load_last = (k == 3);
      rom_ce = (k == 3); rom_addr = 16'h0;
      tick();
      check_eq("run_after_beat", run1, (k == 3) ? 32'd1 : 32'd0);
    end
    load_valid = 1'b0; load_last = 1'b0; rom_ce = 1'b0;
    check_eq("run3_up", run3, 32'd1);
    check_eq("ready1_run", load_ready1, 32'd0);
    check_eq("cnt1_start", fetch_cnt1, 32'd0);
    check_eq("cnt3_start", fetch_cnt3, 32'd0);
    check_eq("valid1_nofetch", rom_valid1, 32'd0);

    // Back-to-back fetches 0..3.
    for (int k = 0; k < 4; k++) begin
      rom_ce = 1'b1; rom_addr = 16'(k);
      tick();
      check_eq("b2b_data1", rom_data1, 32'(prog_w[k]));
      check_eq("b2b_valid1", rom_valid1, 32'd1);
      if (k >= 2) check_eq("b2b_data3", rom_data3, 32'(prog_w[k-2]));
      else        check_eq("b2b_valid3_early", rom_valid3, 32'd0);
    end
    rom_ce = 1'b0;
    tick();
    check_eq("idle_valid1", rom_valid1, 32'd0);
    check_eq("idle_data1", rom_data1, 32'h0);
    check_eq("b2b_data3_2", rom_data3, 32'(prog_w[2]));
    check_eq("cnt1_4", fetch_cnt1, 32'd4);
    check_eq("cnt3_4", fetch_cnt3, 32'd4);
    tick();
    check_eq("b2b_data3_3", rom_data3, 32'(prog_w[3]));
    tick();
    check_eq("idle_valid3", rom_valid3, 32'd0);
    check_eq("idle_data3", rom_data3, 32'hF00D);

    // Single fetch of word 1, then an out-of-range fetch.
    rom_ce = 1'b1; rom_addr = 16'd1;
    tick();
    check_eq("lat1_data", rom_data1, 32'h3481);
    check_eq("lat3_not_yet1", rom_valid3, 32'd0);
    rom_addr = 16'h0040;
    tick();
    check_eq("oor_data1", rom_data1, 32'h0);
    check_eq("oor_valid1", rom_valid1, 32'd1);
    check_eq("lat3_not_yet2", rom_valid3, 32'd0);
    rom_ce = 1'b0;
    tick();
    check_eq("lat3_data", rom_data3, 32'h3481);
    check_eq("lat3_valid", rom_valid3, 32'd1);
    check_eq("lat1_gone", rom_valid1, 32'd0);
    tick();
    check_eq("oor_data3", rom_data3, 32'hF00D);
    check_eq("oor_valid3", rom_valid3, 32'd1);
    tick();
    check_eq("lat3_once", rom_valid3, 32'd0);
    check_eq("cnt3_6", fetch_cnt3, 32'd6);

    // Stop with three fetches in flight on the LATENCY=3 instance.
    rom_ce = 1'b1; rom_addr = 16'd0;
    tick();
    rom_addr = 16'd1;
    tick();
    rom_addr = 16'd3; stop = 1'b1;
    tick();
    check_eq("stop_run1", run1, 32'd0);
    check_eq("stop_run3", run3, 32'd0);
    check_eq("drain_ready3", load_ready3, 32'd0);
    check_eq("drain_ready1", load_ready1, 32'd0);
    check_eq("stop_data1", rom_data1, 32'h1234);
    check_eq("drain_r0", rom_data3, 32'h3443);
    rom_addr = 16'd2;
    tick();
    check_eq("drain_r1", rom_data3, 32'h3481);
    check_eq("drain_v1", rom_valid3, 32'd1);
    check_eq("drain1_done", load_ready1, 32'd1);
    check_eq("drain1_nofetch", rom_valid1, 32'd0);
    check_eq("drain_busy3a", load_ready3, 32'd0);
    tick();
    check_eq("drain_r2", rom_data3, 32'h1234);
    check_eq("drain_busy3b", load_ready3, 32'd0);
    tick();
    check_eq("drain3_done", load_ready3, 32'd1);
    check_eq("drain3_empty", rom_valid3, 32'd0);
    check_eq("cnt3_hold", fetch_cnt3, 32'd9);
    check_eq("cnt1_hold", fetch_cnt1, 32'd9);
    check_eq("load_stop_ign", run1, 32'd0);
    rom_ce = 1'b0; stop = 1'b0;

    // Reload: an out-of-range beat (aliases word 0 if unchecked), then word 2.
    load_valid = 1'b1; load_addr = 16'h0100; load_data = 16'h5555; load_last = 1'b0;
    tick();
    check_eq("err1_set", load_err1, 32'd1);
    check_eq("err3_set", load_err3, 32'd1);
    load_addr = 16'd2; load_data = 16'hBEEF; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check_eq("rerun3", run3, 32'd1);
    check_eq("cnt3_clr", fetch_cnt3, 32'd0);
    check_eq("err3_sticky", load_err3, 32'd1);
    rom_ce = 1'b1; rom_addr = 16'd2;
    tick();
    check_eq("reload_w2", rom_data1, 32'hBEEF);
    rom_addr = 16'd0;
    tick();
    check_eq("reload_w0", rom_data1, 32'h3443);
    rom_ce = 1'b0;
    tick();
    check_eq("reload_w2_3", rom_data3, 32'hBEEF);
    tick();
    check_eq("reload_w0_3", rom_data3, 32'h3443);
    check_eq("cnt1_2", fetch_cnt1, 32'd2);

    // Async reset with two fetches in flight.
    rom_ce = 1'b1; rom_addr = 16'd3;
    tick();
    rom_addr = 16'd1;
    tick();
    rom_ce = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("arst_valid3", rom_valid3, 32'd0);
    check_eq("arst_valid1", rom_valid1, 32'd0);
    check_eq("arst_data3", rom_data3, 32'hF00D);
    check_eq("arst_run3", run3, 32'd0);
    check_eq("arst_ready3", load_ready3, 32'd1);
    check_eq("arst_cnt3", fetch_cnt3, 32'd0);
    check_eq("arst_err3", load_err3, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("post_rst_valid3", rom_valid3, 32'd0);

    // Dropped last beat still starts a run; memory survives the reset.
    load_valid = 1'b1; load_addr = 16'h0200; load_data = 16'h7777; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check_eq("drop_last_run", run1, 32'd1);
    check_eq("drop_last_err", load_err1, 32'd1);
    for (int k = 0; k < 4; k++) begin
      rom_ce = 1'b1; rom_addr = ord_a[k];
      tick();
      check_eq("persist_data1", rom_data1, 32'(ord_e[k]));
      if (k >= 2) check_eq("persist_data3", rom_data3, 32'(ord_e[k-2]));
      else        check_eq("persist_wait3", rom_valid3, 32'd0);
    end
    rom_ce = 1'b0;
    tick();
    check_eq("persist_tail3a", rom_data3, 32'(ord_e[2]));
    tick();
    check_eq("persist_tail3b", rom_data3, 32'(ord_e[3]));
    check_eq("persist_cnt3", fetch_cnt3, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, err_cnt);
    $finish;
  end

endmodule
